// File: rtl/chan_rr_arbiter_pkg.sv
// ============================================================================
// Module  : chan_rr_arbiter_pkg
// Brief   : Shared state encodings, defaults and index helper for the arbiter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package chan_rr_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_MAXHOLD = 4;

    // Modulo-N increment for owner/pointer indices (v is always < n).
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/chan_rr_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational rotate-priority search starting at ptr.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    int c;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        any = |req;
        idx = '0;
        c   = 0;
        for (int s = N - 1; s >= 0; s--) begin
            c = int'(ptr) + s;
            if (c >= N) begin
                c = c - N;
            end
            if (req[c]) begin
                idx = IW'(c);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/chan_rr_arbiter.sv
// ============================================================================
// Module  : chan_rr_arbiter
// Brief   : Round-robin owner of a shared channel with bounded bursts and gap.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module chan_rr_arbiter
    import chan_rr_arbiter_pkg::*;
#(
    parameter  int N       = 2,
    parameter  int W       = 1,
    parameter  int MAXHOLD = DEF_MAXHOLD,
    localparam int IW      = (N > 1) ? $clog2(N) : 1,
    localparam int CW      = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] din,
    output logic [N-1:0]   gnt,
    output logic [IW-1:0]  owner,
    output logic [W-1:0]   chan_d,
    output logic           chan_vld,
    output logic           busy
);

    arb_state_e    state_q;
    logic [IW-1:0] ptr_q;
    logic [CW-1:0] hold_q;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] owner_q;
    logic [W-1:0]  chan_d_q;
    logic          chan_vld_q;
    logic          busy_q;

    logic          w_any;
    logic [IW-1:0] w_pick;
    logic          w_own_req;
    logic [W-1:0]  w_own_din;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (w_any),
        .idx (w_pick)
    );

    // Mux the current owner's request and data lane.
    always_comb begin
        w_own_req = 1'b0;
        w_own_din = '0;
        for (int k = 0; k < N; k++) begin
            if (owner_q == IW'(k)) begin
                w_own_req = req[k];
                w_own_din = din[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            hold_q     <= '0;
            gnt_q      <= '0;
            owner_q    <= '0;
            chan_d_q   <= '0;
            chan_vld_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    chan_vld_q <= 1'b0;
                    if (w_any) begin
                        for (int k = 0; k < N; k++) begin
                            gnt_q[k] <= (w_pick == IW'(k));
                        end
                        owner_q <= w_pick;
                        hold_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    chan_d_q   <= w_own_din;
                    chan_vld_q <= w_own_req;
                    hold_q     <= hold_q + CW'(1);
                    // Release on drop or burst limit; the last beat still goes out.
                    if (!w_own_req || hold_q == CW'(MAXHOLD - 1)) begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= IW'(wrap_inc(int'(owner_q), N));
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign owner    = owner_q;
    assign chan_d   = chan_d_q;
    assign chan_vld = chan_vld_q;
    assign busy     = busy_q;

endmodule

`default_nettype wire
